// File: rtl/pet_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pet_pkg
// Description : Shared types and helpers for the virtual-pet behaviour core.
//               Holds the 4-bit state/face codes, the need-level width and a
//               saturating add/sub used by every level register.
// Revision    : 1.0 - initial release
// ============================================================================
package pet_pkg;

   localparam int LVL_W = 4;

   // State code doubles as the face index sent to the matrix driver.
   typedef enum logic [3:0] {
      ST_NORMAL   = 4'd0,
      ST_HUNGRY   = 4'd1,
      ST_GREET    = 4'd2,
      ST_EATING   = 4'd3,
      ST_PLAYING  = 4'd4,
      ST_SLEEPING = 4'd5,
      ST_TIRED    = 4'd6,
      ST_SAD      = 4'd7,
      ST_DEAD     = 4'd8
   } state_t;

   // Net level update: lvl + inc - dec, clamped to [0, max]. The sum is
   // formed one bit wider so a full level plus a boost cannot wrap.
   function automatic logic [LVL_W-1:0] sat_update(
      input logic [LVL_W-1:0] lvl,
      input logic [LVL_W-1:0] inc,
      input logic [LVL_W-1:0] dec,
      input logic [LVL_W-1:0] max
   );
      logic [LVL_W:0]   sum;
      logic [LVL_W-1:0] res;
      sum = {1'b0, lvl} + {1'b0, inc};
      if (sum <= {1'b0, dec}) begin
         res = '0;
      end else begin
         sum = sum - {1'b0, dec};
         res = (sum > {1'b0, max}) ? max : sum[LVL_W-1:0];
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pet_mood_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : pet_mood_scheduler_if
// Description : Face handshake between the behaviour core and the LED-matrix
//               face driver.
//   face_code : face index (state code), stable while face_req is high
//   face_req  : a new face is pending
//   face_ack  : single-cycle pulse, driver has taken face_code
// Revision    : 1.0 - initial release
// ============================================================================
interface pet_mood_scheduler_if;
   logic [3:0] face_code;
   logic       face_req;
   logic       face_ack;

   modport master (output face_code, output face_req, input  face_ack);
   modport slave  (input  face_code, input  face_req, output face_ack);
endinterface
`default_nettype wire

// File: rtl/sec_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : sec_prescaler
// Description : Divides clk down to a one-cycle pulse once per second.
//   clk      : system clock
//   reset    : asynchronous, active-high
//   sec_tick : high in the cycle the prescaler wraps from CLK_HZ-1 to 0
// Revision    : 1.0 - initial release
// ============================================================================
module sec_prescaler #(
   parameter int CLK_HZ = 50000000
)(
   input  logic clk,
   input  logic reset,
   output logic sec_tick
);

   localparam int c_CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(CLK_HZ - 1);

   logic [c_CW-1:0] r_cnt;
   logic            w_wrap;

   assign w_wrap   = (r_cnt == c_LAST);
   assign sec_tick = w_wrap;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + c_CW'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/pet_mood_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pet_mood_scheduler
// Description : Virtual-pet behaviour controller. Keeps fullness/energy/joy,
//               decays them on the 1 Hz tick, arbitrates feed/play/sleep and
//               proximity into one pet state, and pushes that state as a face
//               code to the matrix driver over a req/ack handshake.
//   clk, reset          : clock, asynchronous active-high reset
//   feed_p/play_p/sleep_p : debounced single-cycle button pulses
//   dist_cm             : ultrasonic distance, valid every cycle
//   face_if (master)    : face_code / face_req / face_ack handshake
//   fullness/energy/joy : current need levels
//   sec_tick            : one-cycle pulse per second
// Revision    : 1.0 - initial release
// ============================================================================
module pet_mood_scheduler
   import pet_pkg::*;
#(
   parameter int CLK_HZ  = 50000000,
   parameter int LVL_MAX = 10,
   parameter int LVL_LOW = 3,
   parameter int DECAY_S = 6,
   parameter int ACT_S   = 3,
   parameter int NEAR_CM = 5,
   parameter int BOOST   = 3
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 feed_p,
   input  logic                 play_p,
   input  logic                 sleep_p,
   input  logic [15:0]          dist_cm,
   pet_mood_scheduler_if.master face_if,
   output logic [LVL_W-1:0]     fullness,
   output logic [LVL_W-1:0]     energy,
   output logic [LVL_W-1:0]     joy,
   output logic                 sec_tick
);

   localparam int c_DCW = (DECAY_S > 1) ? $clog2(DECAY_S) : 1;
   localparam int c_ACW = (ACT_S > 1) ? $clog2(ACT_S) : 1;
   localparam logic [LVL_W-1:0] c_LVL_MAX = LVL_W'(LVL_MAX);
   localparam logic [LVL_W-1:0] c_LVL_LOW = LVL_W'(LVL_LOW);
   localparam logic [LVL_W-1:0] c_BOOST   = LVL_W'(BOOST);
   localparam logic [LVL_W-1:0] c_ONE     = LVL_W'(1);

   state_t            r_state, w_next, w_mood, r_face_code;
   logic              r_face_req;
   logic [LVL_W-1:0]  r_full, r_energy, r_joy;
   logic [c_DCW-1:0]  r_decay_cnt;
   logic [c_ACW-1:0]  r_act_cnt;

   logic              w_tick, w_near, w_decay, w_dead_cond, w_act_done;
   logic              w_feed_go, w_play_go, w_greet_inc, w_freeze;
   logic [LVL_W-1:0]  w_full_inc, w_full_dec, w_en_inc, w_en_dec;
   logic [LVL_W-1:0]  w_joy_inc, w_joy_dec;

   sec_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .sec_tick (w_tick)
   );

   assign sec_tick    = w_tick;
   assign fullness    = r_full;
   assign energy      = r_energy;
   assign joy         = r_joy;
   assign face_if.face_code = r_face_code;
   assign face_if.face_req  = r_face_req;

   assign w_near      = (dist_cm <= 16'(NEAR_CM));
   assign w_decay     = w_tick && (r_decay_cnt == c_DCW'(DECAY_S - 1));
   assign w_dead_cond = (r_full == '0) && (r_energy == '0);
   assign w_act_done  = w_tick && (r_act_cnt == c_ACW'(ACT_S - 1));
   // Levels stop moving once DEAD is reached or about to be entered.
   assign w_freeze    = (r_state == ST_DEAD) || w_dead_cond;

   // Mood resolution from the current levels.
   always_comb begin
      w_mood = ST_NORMAL;
      if (r_full <= c_LVL_LOW) begin
         w_mood = ST_HUNGRY;
      end else if (r_energy <= c_LVL_LOW) begin
         w_mood = ST_TIRED;
      end else if (r_joy <= c_LVL_LOW) begin
         w_mood = ST_SAD;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_NORMAL;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and action decode.
   always_comb begin
      w_next      = r_state;
      w_feed_go   = 1'b0;
      w_play_go   = 1'b0;
      if (r_state == ST_DEAD) begin
         w_next = ST_DEAD;
      end else if (w_dead_cond) begin
         w_next = ST_DEAD;
      end else begin
         case (r_state)
            ST_EATING, ST_PLAYING: begin
               if (w_act_done) w_next = w_mood;
            end
            ST_SLEEPING: begin
               if (w_near) begin
                  w_next = ST_GREET;
               end else if (sleep_p || (r_energy == c_LVL_MAX)) begin
                  w_next = w_mood;
               end
            end
            default: begin
               if (feed_p) begin
                  w_next    = ST_EATING;
                  w_feed_go = 1'b1;
               end else if (sleep_p) begin
                  w_next = ST_SLEEPING;
               end else if (play_p && (r_energy >= LVL_W'(2))) begin
                  w_next    = ST_PLAYING;
                  w_play_go = 1'b1;
               end else if (w_near) begin
                  w_next = ST_GREET;
               end else begin
                  w_next = w_mood;
               end
            end
         endcase
      end
      w_greet_inc = (w_next == ST_GREET) && (r_state != ST_GREET);
   end

   // Per-level increments/decrements; combined into one clamped update.
   always_comb begin
      w_full_inc = w_feed_go ? c_BOOST : '0;
      w_full_dec = w_decay ? c_ONE : '0;
      w_joy_inc  = (w_play_go ? c_BOOST : '0) + (w_greet_inc ? c_ONE : '0);
      w_joy_dec  = w_decay ? c_ONE : '0;
      w_en_inc   = '0;
      w_en_dec   = '0;
      if (r_state == ST_SLEEPING) begin
         // Sleep recharges every second instead of decaying.
         w_en_inc = w_tick ? c_ONE : '0;
      end else begin
         w_en_dec = (w_decay ? c_ONE : '0) + (w_play_go ? c_ONE : '0);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_full   <= c_LVL_MAX;
         r_energy <= c_LVL_MAX;
         r_joy    <= c_LVL_MAX;
      end else if (!w_freeze) begin
         r_full   <= sat_update(r_full,   w_full_inc, w_full_dec, c_LVL_MAX);
         r_energy <= sat_update(r_energy, w_en_inc,   w_en_dec,   c_LVL_MAX);
         r_joy    <= sat_update(r_joy,    w_joy_inc,  w_joy_dec,  c_LVL_MAX);
      end
   end

   // Second counters: decay interval and time spent eating/playing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_decay_cnt <= '0;
         r_act_cnt   <= '0;
      end else begin
         if (w_tick) begin
            r_decay_cnt <= (r_decay_cnt == c_DCW'(DECAY_S - 1)) ?
                           '0 : r_decay_cnt + c_DCW'(1);
         end
         if (w_feed_go || w_play_go) begin
            r_act_cnt <= '0;
         end else if (((r_state == ST_EATING) || (r_state == ST_PLAYING)) &&
                      w_tick && !w_act_done) begin
            r_act_cnt <= r_act_cnt + c_ACW'(1);
         end
      end
   end

   // Face handshake: a face is only loaded while no request is outstanding,
   // and always from the current state, so intermediate states collapse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_face_code <= ST_NORMAL;
         r_face_req  <= 1'b1;
      end else if (r_face_req) begin
         if (face_if.face_ack) r_face_req <= 1'b0;
      end else if (r_state != r_face_code) begin
         r_face_code <= r_state;
         r_face_req  <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pet_mood_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pet_mood_scheduler
// Description : Directed self-checking bench for pet_mood_scheduler with a
//               10-cycle second, 2-second decay and 3-second actions. A small
//               driver model answers every face request after two cycles and
//               logs the faces it accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pet_mood_scheduler;

   logic        clk;
   logic        reset;
   logic        feed_p, play_p, sleep_p;
   logic [15:0] dist_cm;
   logic [3:0]  fullness, energy, joy;
   logic        sec_tick;

   pet_mood_scheduler_if bus();

   pet_mood_scheduler #(
      .CLK_HZ (10),
      .DECAY_S(2),
      .ACT_S  (3)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .feed_p   (feed_p),
      .play_p   (play_p),
      .sleep_p  (sleep_p),
      .dist_cm  (dist_cm),
      .face_if  (bus),
      .fullness (fullness),
      .energy   (energy),
      .joy      (joy),
      .sec_tick (sec_tick)
   );

   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_sent   = 0;
   int   ack_cnt  = 0;
   logic ack_en   = 1'b0;
   logic [3:0] last_sent = 4'd0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input logic f, input logic p, input logic s);
      feed_p  = f;
      play_p  = p;
      sleep_p = s;
      @(negedge clk);
      feed_p  = 1'b0;
      play_p  = 1'b0;
      sleep_p = 1'b0;
   endtask

   // Returns at the negedge of the cycle right after the n-th tick.
   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         int k;
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (!sec_tick && k < 40);
         if (!sec_tick) check_eq("tick_wait_timeout", 0, 1);
      end
      @(negedge clk);
   endtask

   // Matrix driver model: ack two cycles after seeing a request.
   initial begin
      bus.face_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.face_ack = 1'b0;
         if (ack_en && bus.face_req && !reset) begin
            ack_cnt++;
            if (ack_cnt == 2) begin
               bus.face_ack = 1'b1;
               last_sent    = bus.face_code;
               n_sent++;
               ack_cnt      = 0;
            end
         end else begin
            ack_cnt = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1);
   end

   initial begin
      reset   = 1'b1;
      feed_p  = 1'b0;
      play_p  = 1'b0;
      sleep_p = 1'b0;
      dist_cm = 16'd100;
      cyc(3);
      check_eq("rst_full",  int'(fullness), 10);
      check_eq("rst_energy", int'(energy), 10);
      check_eq("rst_joy",   int'(joy), 10);
      check_eq("rst_face",  int'(bus.face_code), 0);
      check_eq("rst_req",   int'(bus.face_req), 1);
      check_eq("rst_tick",  int'(sec_tick), 0);
      ack_en = 1'b1;
      reset  = 1'b0;

      // Idle decay: 8 ticks = 4 decay steps.
      wait_ticks(8);
      check_eq("t1_full",   int'(fullness), 6);
      check_eq("t1_energy", int'(energy), 6);
      check_eq("t1_joy",    int'(joy), 6);
      check_eq("t1_face",   int'(bus.face_code), 0);
      check_eq("t1_nsent",  n_sent, 1);
      wait_ticks(6);
      check_eq("t1_full3",  int'(fullness), 3);
      cyc(8);
      check_eq("t1_hungry_face", int'(bus.face_code), 1);
      check_eq("t1_hungry_nsent", n_sent, 2);
      wait_ticks(1);

      // Feed and play together: feed wins, joy untouched.
      pulse(1'b1, 1'b1, 1'b0);
      check_eq("t2_full",   int'(fullness), 6);
      check_eq("t2_joy",    int'(joy), 3);
      check_eq("t2_energy", int'(energy), 3);
      wait_ticks(3);
      check_eq("t2_full_after", int'(fullness), 4);
      check_eq("t2_energy_after", int'(energy), 1);
      cyc(6);
      check_eq("t2_tired_face", int'(bus.face_code), 6);
      check_eq("t2_nsent", n_sent, 4);

      // Play with energy 1 is ignored.
      pulse(1'b0, 1'b1, 1'b0);
      check_eq("t3_energy", int'(energy), 1);
      check_eq("t3_joy",    int'(joy), 1);
      check_eq("t3_req0",   int'(bus.face_req), 0);
      cyc(1);
      check_eq("t3_req1",   int'(bus.face_req), 0);
      check_eq("t3_face",   int'(bus.face_code), 6);
      wait_ticks(1);

      // Sleep recharges energy one per second.
      pulse(1'b0, 1'b0, 1'b1);
      wait_ticks(4);
      check_eq("t4_energy", int'(energy), 5);
      check_eq("t4_full",   int'(fullness), 2);
      check_eq("t4_joy",    int'(joy), 0);
      check_eq("t4_face",   int'(bus.face_code), 5);
      check_eq("t4_nsent",  n_sent, 5);
      pulse(1'b0, 1'b0, 1'b1);
      cyc(4);
      pulse(1'b0, 1'b1, 1'b0);
      check_eq("t3_play_joy",    int'(joy), 3);
      check_eq("t3_play_energy", int'(energy), 4);
      check_eq("t3_play_nsent",  n_sent, 6);
      wait_ticks(3);
      check_eq("t3_end_full",   int'(fullness), 0);
      check_eq("t3_end_energy", int'(energy), 2);
      check_eq("t3_end_joy",    int'(joy), 1);
      cyc(3);
      check_eq("t3_end_face",   int'(bus.face_code), 1);
      check_eq("t3_end_nsent",  n_sent, 8);

      // Withhold ack across three state changes.
      ack_en = 1'b0;
      pulse(1'b0, 1'b0, 1'b1);
      cyc(1);
      pulse(1'b0, 1'b0, 1'b1);
      pulse(1'b1, 1'b0, 1'b0);
      cyc(1);
      check_eq("t5_frozen_face", int'(bus.face_code), 5);
      check_eq("t5_frozen_req",  int'(bus.face_req), 1);
      check_eq("t5_full",        int'(fullness), 3);
      check_eq("t5_nsent_hold",  n_sent, 8);
      ack_en = 1'b1;
      cyc(10);
      check_eq("t5_final_face",  int'(bus.face_code), 3);
      check_eq("t5_last_sent",   int'(last_sent), 3);
      check_eq("t5_nsent",       n_sent, 10);
      wait_ticks(2);
      check_eq("t5_full_after",   int'(fullness), 2);
      check_eq("t5_energy_after", int'(energy), 1);

      // Decay into DEAD.
      wait_ticks(3);
      cyc(6);
      check_eq("t6_face",   int'(bus.face_code), 8);
      check_eq("t6_full",   int'(fullness), 0);
      check_eq("t6_energy", int'(energy), 0);
      check_eq("t6_nsent",  n_sent, 12);
      feed_p  = 1'b1;
      play_p  = 1'b1;
      sleep_p = 1'b1;
      dist_cm = 16'd4;
      cyc(3);
      feed_p  = 1'b0;
      play_p  = 1'b0;
      sleep_p = 1'b0;
      dist_cm = 16'd100;
      cyc(1);
      check_eq("t6_dead_face", int'(bus.face_code), 8);
      check_eq("t6_dead_req",  int'(bus.face_req), 0);
      check_eq("t6_dead_full", int'(fullness), 0);
      check_eq("t6_dead_joy",  int'(joy), 0);

      // Asynchronous reset mid-DEAD.
      #2;
      ack_en = 1'b0;
      reset  = 1'b1;
      #1;
      check_eq("t6_rst_full",   int'(fullness), 10);
      check_eq("t6_rst_energy", int'(energy), 10);
      check_eq("t6_rst_face",   int'(bus.face_code), 0);
      check_eq("t6_rst_req",    int'(bus.face_req), 1);
      @(negedge clk);
      n_sent = 0;
      ack_en = 1'b1;
      reset  = 1'b0;
      cyc(1);
      check_eq("t6_rel_face", int'(bus.face_code), 0);
      check_eq("t6_rel_req",  int'(bus.face_req), 1);

      // Play at full levels: joy clamps at 10.
      pulse(1'b0, 1'b1, 1'b0);
      check_eq("t7_joy_clamp", int'(joy), 10);
      check_eq("t7_energy",    int'(energy), 9);
      wait_ticks(3);
      check_eq("t7_energy_after", int'(energy), 8);

      // Sleep until energy reaches 10, then auto wake.
      pulse(1'b0, 1'b0, 1'b1);
      wait_ticks(2);
      check_eq("t8_energy_max", int'(energy), 10);
      check_eq("t8_full",       int'(fullness), 8);
      cyc(6);
      check_eq("t8_wake_face",  int'(bus.face_code), 0);
      check_eq("t8_nsent",      n_sent, 5);

      // Proximity at exactly NEAR_CM wakes into GREET.
      wait_ticks(1);
      pulse(1'b0, 1'b0, 1'b1);
      dist_cm = 16'd5;
      cyc(1);
      check_eq("t9_greet_joy", int'(joy), 8);
      cyc(5);
      check_eq("t9_hold_joy",  int'(joy), 8);
      check_eq("t9_face",      int'(bus.face_code), 2);
      check_eq("t9_nsent",     n_sent, 7);
      dist_cm = 16'd6;
      cyc(6);
      check_eq("t9_far_face",  int'(bus.face_code), 0);
      check_eq("t9_far_nsent", n_sent, 8);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
